// File: rtl/ps2_scancode_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder_pkg
// Shared definitions for the PS/2 set-2 scan-code decoder:
//   - prefix bytes (extended E0, break F0)
//   - state types for the FIFO pop FSM and the byte-sequence FSM
//   - digit-enable masks for the digital_led driver
//   - BCD helpers used by the press counter
// ---------------------------------------------------------------------------
package ps2_scancode_decoder_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] DISP_HELD = 8'h3F;
    localparam logic [7:0] DISP_IDLE = 8'h30;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_POP,
        HS_GAP
    } hs_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_EXT,
        B_BRK,
        B_EXTBRK
    } b_state_t;

    // Binary 0..99 to packed {tens,ones} BCD; used for the wrap constant.
    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // One BCD step; returns 00 once the wrap value has been reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] wrap_bcd);
        if (v == wrap_bcd) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_scan2ascii.sv
// ---------------------------------------------------------------------------
// ps2_scan2ascii
// Combinational set-2 make code to lower-case ASCII lookup.
// Covers a-z, 0-9, space and enter (0x0D); anything else maps to 0x00.
// Ports:
//   code_i   in  8  set-2 make code (low byte, no E0 prefix)
//   ascii_o  out 8  ASCII character or 0x00
// ---------------------------------------------------------------------------
module ps2_scan2ascii (
    input  logic [7:0] code_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (code_i)
            8'h1C: ascii_o = 8'h61; // a
            8'h32: ascii_o = 8'h62; // b
            8'h21: ascii_o = 8'h63; // c
            8'h23: ascii_o = 8'h64; // d
            8'h24: ascii_o = 8'h65; // e
            8'h2B: ascii_o = 8'h66; // f
            8'h34: ascii_o = 8'h67; // g
            8'h33: ascii_o = 8'h68; // h
            8'h43: ascii_o = 8'h69; // i
            8'h3B: ascii_o = 8'h6A; // j
            8'h42: ascii_o = 8'h6B; // k
            8'h4B: ascii_o = 8'h6C; // l
            8'h3A: ascii_o = 8'h6D; // m
            8'h31: ascii_o = 8'h6E; // n
            8'h44: ascii_o = 8'h6F; // o
            8'h4D: ascii_o = 8'h70; // p
            8'h15: ascii_o = 8'h71; // q
            8'h2D: ascii_o = 8'h72; // r
            8'h1B: ascii_o = 8'h73; // s
            8'h2C: ascii_o = 8'h74; // t
            8'h3C: ascii_o = 8'h75; // u
            8'h2A: ascii_o = 8'h76; // v
            8'h1D: ascii_o = 8'h77; // w
            8'h22: ascii_o = 8'h78; // x
            8'h35: ascii_o = 8'h79; // y
            8'h1A: ascii_o = 8'h7A; // z
            8'h45: ascii_o = 8'h30; // 0
            8'h16: ascii_o = 8'h31; // 1
            8'h1E: ascii_o = 8'h32; // 2
            8'h26: ascii_o = 8'h33; // 3
            8'h25: ascii_o = 8'h34; // 4
            8'h2E: ascii_o = 8'h35; // 5
            8'h36: ascii_o = 8'h36; // 6
            8'h3D: ascii_o = 8'h37; // 7
            8'h3E: ascii_o = 8'h38; // 8
            8'h46: ascii_o = 8'h39; // 9
            8'h29: ascii_o = 8'h20; // space
            8'h5A: ascii_o = 8'h0D; // enter
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
// Pops bytes from the ps2_keyboard FIFO, decodes set-2 make/break/E0
// sequences, tracks the held key, counts presses in BCD and drives the
// digit enables of the digital_led display. Recovers the receiver on
// FIFO overflow by pulsing clrn low.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   ps2_data_i     FIFO head byte
//   ps2_ready_i    FIFO non-empty
//   ps2_ovf_i      FIFO overflow
//   ps2_next_n_o   active-low pop strobe (one cycle per byte)
//   ps2_clrn_o     active-low receiver clear
//   scan_o/ext_o   last make code and its E0 flag
//   ascii_o        lower-case ASCII of scan_o (0 if unmapped or extended)
//   cnt_bcd_o      press count {tens,ones}
//   key_down_o     a key is held
//   disp_en_o      digit enables: [1:0] scan, [3:2] ascii, [5:4] count
// ---------------------------------------------------------------------------
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int CNT_MAX    = 99,
    parameter int CLR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_data_i,
    input  logic       ps2_ready_i,
    input  logic       ps2_ovf_i,
    output logic       ps2_next_n_o,
    output logic       ps2_clrn_o,
    output logic [7:0] scan_o,
    output logic       ext_o,
    output logic [7:0] ascii_o,
    output logic [7:0] cnt_bcd_o,
    output logic       key_down_o,
    output logic [7:0] disp_en_o
);

    localparam logic [7:0] CNT_WRAP_BCD = to_bcd(CNT_MAX);
    localparam int         CLR_W        = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES);
    localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);

    hs_state_t        hs_q, hs_d;
    b_state_t         b_q, b_d;
    logic [7:0]       byte_q, byte_d;
    logic             next_n_q, next_n_d;
    logic             clrn_q, clrn_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]       scan_q, scan_d;
    logic             ext_q, ext_d;
    logic [7:0]       ascii_q, ascii_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             key_down_q, key_down_d;
    logic [7:0]       disp_en_q, disp_en_d;

    logic [7:0] lut_ascii;
    logic       do_make, do_brk, ev_ext, is_held;

    ps2_scan2ascii u_scan2ascii (
        .code_i  (byte_q),
        .ascii_o (lut_ascii)
    );

    always_comb begin
        hs_d       = hs_q;
        b_d        = b_q;
        byte_d     = byte_q;
        next_n_d   = next_n_q;
        clrn_d     = clrn_q;
        clr_cnt_d  = clr_cnt_q;
        scan_d     = scan_q;
        ext_d      = ext_q;
        ascii_d    = ascii_q;
        cnt_d      = cnt_q;
        key_down_d = key_down_q;
        do_make    = 1'b0;
        do_brk     = 1'b0;
        ev_ext     = 1'b0;

        if (ps2_ovf_i) begin
            // Overflow abandons any byte in flight and any partial sequence.
            clr_cnt_d  = CLR_LOAD;
            clrn_d     = 1'b0;
            hs_d       = HS_IDLE;
            b_d        = B_IDLE;
            next_n_d   = 1'b1;
            key_down_d = 1'b0;
        end else begin
            // clrn rises on the edge where the timer runs out.
            if (clr_cnt_q != '0) begin
                clr_cnt_d = clr_cnt_q - CLR_ONE;
                clrn_d    = (clr_cnt_q == CLR_ONE);
            end

            case (hs_q)
                HS_IDLE: begin
                    // Gating on clrn_q keeps the FIFO untouched while it is being cleared.
                    if (ps2_ready_i && clrn_q) begin
                        byte_d   = ps2_data_i;
                        next_n_d = 1'b0;
                        hs_d     = HS_POP;
                    end
                end
                HS_POP: begin
                    next_n_d = 1'b1;
                    hs_d     = HS_GAP;
                    case (b_q)
                        B_IDLE: begin
                            if (byte_q == PS2_EXT) begin
                                b_d = B_EXT;
                            end else if (byte_q == PS2_BRK) begin
                                b_d = B_BRK;
                            end else begin
                                do_make = 1'b1;
                            end
                        end
                        B_EXT: begin
                            if (byte_q == PS2_BRK) begin
                                b_d = B_EXTBRK;
                            end else if (byte_q != PS2_EXT) begin
                                do_make = 1'b1;
                                ev_ext  = 1'b1;
                                b_d     = B_IDLE;
                            end
                        end
                        B_BRK: begin
                            do_brk = 1'b1;
                            b_d    = B_IDLE;
                        end
                        default: begin
                            do_brk = 1'b1;
                            ev_ext = 1'b1;
                            b_d    = B_IDLE;
                        end
                    endcase
                end
                default: hs_d = HS_IDLE;
            endcase
        end

        // The held key is always the last accepted make, so scan/ext double as its identity.
        is_held = key_down_q && ({ev_ext, byte_q} == {ext_q, scan_q});

        if (do_make && !is_held) begin
            scan_d     = byte_q;
            ext_d      = ev_ext;
            ascii_d    = ev_ext ? 8'h00 : lut_ascii;
            key_down_d = 1'b1;
            cnt_d      = bcd_inc(cnt_q, CNT_WRAP_BCD);
        end
        if (do_brk && is_held) begin
            key_down_d = 1'b0;
        end

        disp_en_d = key_down_d ? DISP_HELD : DISP_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q       <= HS_IDLE;
            b_q        <= B_IDLE;
            next_n_q   <= 1'b1;
            clrn_q     <= 1'b0;
            clr_cnt_q  <= CLR_ONE;
            scan_q     <= 8'h00;
            ext_q      <= 1'b0;
            ascii_q    <= 8'h00;
            cnt_q      <= 8'h00;
            key_down_q <= 1'b0;
            disp_en_q  <= DISP_IDLE;
        end else begin
            hs_q       <= hs_d;
            b_q        <= b_d;
            next_n_q   <= next_n_d;
            clrn_q     <= clrn_d;
            clr_cnt_q  <= clr_cnt_d;
            scan_q     <= scan_d;
            ext_q      <= ext_d;
            ascii_q    <= ascii_d;
            cnt_q      <= cnt_d;
            key_down_q <= key_down_d;
            disp_en_q  <= disp_en_d;
        end
    end

    // Captured byte is pure data; it is only consumed in HS_POP after a capture.
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    assign ps2_next_n_o = next_n_q;
    assign ps2_clrn_o   = clrn_q;
    assign scan_o       = scan_q;
    assign ext_o        = ext_q;
    assign ascii_o      = ascii_q;
    assign cnt_bcd_o    = cnt_q;
    assign key_down_o   = key_down_q;
    assign disp_en_o    = disp_en_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_decoder
// Bench for ps2_scancode_decoder: a queue stands in for the receiver FIFO,
// a keyboard-level model tracks prefixes, the held key and the press count.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_data_i = 8'h00;
    logic       ps2_ready_i = 1'b0;
    logic       ps2_ovf_i = 1'b0;
    logic       ps2_next_n_o, ps2_clrn_o, ext_o, key_down_o;
    logic [7:0] scan_o, ascii_o, cnt_bcd_o, disp_en_o;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.CNT_MAX(99), .CLR_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_data_i   (ps2_data_i),
        .ps2_ready_i  (ps2_ready_i),
        .ps2_ovf_i    (ps2_ovf_i),
        .ps2_next_n_o (ps2_next_n_o),
        .ps2_clrn_o   (ps2_clrn_o),
        .scan_o       (scan_o),
        .ext_o        (ext_o),
        .ascii_o      (ascii_o),
        .cnt_bcd_o    (cnt_bcd_o),
        .key_down_o   (key_down_o),
        .disp_en_o    (disp_en_o)
    );

    localparam logic [7:0] LETTER_SC [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_SC [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] MK_CODES [6] = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'h45};
    localparam logic [7:0] RND_POOL [9] = '{8'hE0, 8'hF0, 8'hF0, 8'h1C, 8'h75, 8'h29, 8'h1C, 8'h75, 8'h5A};

    typedef struct {
        logic [7:0] b;
        logic [7:0] scan;
        logic       ext;
        logic [7:0] ascii;
        logic [7:0] cnt;
        logic       kd;
    } vec_t;

    vec_t tbl [24];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fifo [$];
    int   pushed = 0;
    int   popped = 0;
    int   cyc = 0;
    int   last_pop = -100;
    bit   chk_pend = 1'b0;
    logic [7:0] mon_b;

    // Keyboard-level reference state.
    bit         m_extp, m_brk, m_kd, m_ext;
    logic [7:0] m_scan;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ascii_ref(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (LETTER_SC[i] == c) return 8'(97 + i);
        for (int i = 0; i < 10; i++) if (DIGIT_SC[i] == c) return 8'(48 + i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    function automatic void model_reset();
        m_extp = 0; m_brk = 0; m_kd = 0; m_ext = 0; m_scan = 8'h00; m_cnt = 0;
    endfunction

    function automatic void model_ovf();
        m_extp = 0; m_brk = 0; m_kd = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_brk) begin
            if (m_kd && m_ext == m_extp && m_scan == b) m_kd = 0;
            m_brk = 0;
            m_extp = 0;
        end else if (b == 8'hE0) begin
            m_extp = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!m_kd || m_ext != m_extp || m_scan != b) begin
                m_scan = b;
                m_ext  = m_extp;
                m_kd   = 1;
                m_cnt  = (m_cnt + 1) % 100;
            end
            m_extp = 0;
        end
    endfunction

    task automatic check_model();
        chk("mdl_scan", 32'(scan_o), 32'(m_scan));
        chk("mdl_ext", 32'(ext_o), 32'(m_ext));
        chk("mdl_ascii", 32'(ascii_o), 32'(m_ext ? 8'h00 : ascii_ref(m_scan)));
        chk("mdl_cnt", 32'(cnt_bcd_o), 32'({4'(m_cnt / 10), 4'(m_cnt % 10)}));
        chk("mdl_key_down", 32'(key_down_o), 32'(m_kd));
        chk("mdl_disp_en", 32'(disp_en_o), m_kd ? 32'h3F : 32'h30);
    endtask

    function automatic void refresh();
        ps2_ready_i = (fifo.size() > 0);
        ps2_data_i  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        pushed++;
        refresh();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((fifo.size() > 0 || chk_pend) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_done", 32'(fifo.size() == 0 && !chk_pend), 32'd1);
    endtask

    // FIFO side: pop on the strobe, check spacing, then check the decode one cycle later.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_pend) begin
            chk_pend = 1'b0;
            check_model();
        end
        if (!reset && !ps2_clrn_o) chk("no_pop_in_clear", 32'(ps2_next_n_o), 32'd1);
        if (!ps2_next_n_o) begin
            chk("pop_spacing", 32'(cyc - last_pop >= 3), 32'd1);
            last_pop = cyc;
            chk("pop_nonempty", 32'(fifo.size() > 0), 32'd1);
            if (fifo.size() > 0) begin
                mon_b = fifo.pop_front();
                popped++;
                model_byte(mon_b);
                chk_pend = 1'b1;
                refresh();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_next_n"}, 32'(ps2_next_n_o), 32'd1);
        chk({tag, "_clrn"}, 32'(ps2_clrn_o), 32'd0);
        chk({tag, "_scan"}, 32'(scan_o), 32'h00);
        chk({tag, "_ext"}, 32'(ext_o), 32'd0);
        chk({tag, "_ascii"}, 32'(ascii_o), 32'h00);
        chk({tag, "_cnt"}, 32'(cnt_bcd_o), 32'h00);
        chk({tag, "_key_down"}, 32'(key_down_o), 32'd0);
        chk({tag, "_disp_en"}, 32'(disp_en_o), 32'h30);
    endtask

    initial begin
        int lows;
        tbl[0]  = '{8'h1C, 8'h1C, 1'b0, 8'h61, 8'h01, 1'b1};
        tbl[1]  = '{8'hF0, 8'h1C, 1'b0, 8'h61, 8'h01, 1'b1};
        tbl[2]  = '{8'h1C, 8'h1C, 1'b0, 8'h61, 8'h01, 1'b0};
        tbl[3]  = '{8'h1C, 8'h1C, 1'b0, 8'h61, 8'h02, 1'b1};
        tbl[4]  = '{8'h1C, 8'h1C, 1'b0, 8'h61, 8'h02, 1'b1};
        tbl[5]  = '{8'h1C, 8'h1C, 1'b0, 8'h61, 8'h02, 1'b1};
        tbl[6]  = '{8'hF0, 8'h1C, 1'b0, 8'h61, 8'h02, 1'b1};
        tbl[7]  = '{8'h1C, 8'h1C, 1'b0, 8'h61, 8'h02, 1'b0};
        tbl[8]  = '{8'hE0, 8'h1C, 1'b0, 8'h61, 8'h02, 1'b0};
        tbl[9]  = '{8'h75, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[10] = '{8'hF0, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[11] = '{8'h75, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[12] = '{8'hE0, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[13] = '{8'h75, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[14] = '{8'hE0, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[15] = '{8'hF0, 8'h75, 1'b1, 8'h00, 8'h03, 1'b1};
        tbl[16] = '{8'h75, 8'h75, 1'b1, 8'h00, 8'h03, 1'b0};
        tbl[17] = '{8'h32, 8'h32, 1'b0, 8'h62, 8'h04, 1'b1};
        tbl[18] = '{8'h29, 8'h29, 1'b0, 8'h20, 8'h05, 1'b1};
        tbl[19] = '{8'h5A, 8'h5A, 1'b0, 8'h0D, 8'h06, 1'b1};
        tbl[20] = '{8'h45, 8'h45, 1'b0, 8'h30, 8'h07, 1'b1};
        tbl[21] = '{8'h16, 8'h16, 1'b0, 8'h31, 8'h08, 1'b1};
        tbl[22] = '{8'h76, 8'h76, 1'b0, 8'h00, 8'h09, 1'b1};
        tbl[23] = '{8'h4D, 8'h4D, 1'b0, 8'h70, 8'h10, 1'b1};

        // Reset state, then clrn released one cycle after reset drops.
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_clrn_release", 32'(ps2_clrn_o), 32'd1);

        // Directed byte table.
        for (int i = 0; i < 24; i++) begin
            push(tbl[i].b);
            drain(40);
            chk($sformatf("tbl%0d_scan", i), 32'(scan_o), 32'(tbl[i].scan));
            chk($sformatf("tbl%0d_ext", i), 32'(ext_o), 32'(tbl[i].ext));
            chk($sformatf("tbl%0d_ascii", i), 32'(ascii_o), 32'(tbl[i].ascii));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt_bcd_o), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_key_down", i), 32'(key_down_o), 32'(tbl[i].kd));
            chk($sformatf("tbl%0d_disp_en", i), 32'(disp_en_o), tbl[i].kd ? 32'h3F : 32'h30);
        end

        // Count wrap: 99 make/break pairs back to back, then the 100th press.
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 99; i++) begin
            push(MK_CODES[i % 6]);
            push(8'hF0);
            push(MK_CODES[i % 6]);
        end
        drain(3000);
        chk("wrap_cnt_99", 32'(cnt_bcd_o), 32'h99);
        chk("wrap_released", 32'(key_down_o), 32'd0);
        push(8'h1C);
        drain(40);
        chk("wrap_cnt_00", 32'(cnt_bcd_o), 32'h00);
        chk("wrap_key_down", 32'(key_down_o), 32'd1);

        // Overflow in the middle of E0 F0 while 1C is held.
        push(8'hE0);
        push(8'hF0);
        drain(40);
        @(negedge clk);
        ps2_ovf_i = 1'b1;
        model_ovf();
        @(negedge clk);
        ps2_ovf_i = 1'b0;
        chk("ovf_key_down", 32'(key_down_o), 32'd0);
        chk("ovf_disp_en", 32'(disp_en_o), 32'h30);
        lows = ps2_clrn_o ? 0 : 1;
        push(8'h1C);
        repeat (5) begin
            @(negedge clk);
            if (!ps2_clrn_o) lows++;
        end
        chk("ovf_clrn_low_cycles", 32'(lows), 32'd2);
        drain(40);
        chk("ovf_after_scan", 32'(scan_o), 32'h1C);
        chk("ovf_after_ext", 32'(ext_o), 32'd0);
        chk("ovf_after_key_down", 32'(key_down_o), 32'd1);
        chk("ovf_after_cnt", 32'(cnt_bcd_o), 32'h01);

        // Reset while a break is pending and the FIFO is ready.
        push(8'hF0);
        drain(40);
        @(negedge clk);
        reset = 1'b1;
        push(8'h1C);
        model_reset();
        @(negedge clk);
        #1;
        chk_reset_values("midrst");
        reset = 1'b0;
        drain(40);
        chk("midrst_make_scan", 32'(scan_o), 32'h1C);
        chk("midrst_make_key_down", 32'(key_down_o), 32'd1);
        chk("midrst_make_cnt", 32'(cnt_bcd_o), 32'h01);

        // Randomized bursts and occasional overflow, checked by the model.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                drain(60);
                @(negedge clk);
                ps2_ovf_i = 1'b1;
                model_ovf();
                @(negedge clk);
                ps2_ovf_i = 1'b0;
            end else begin
                repeat ($urandom_range(1, 4)) push(RND_POOL[$urandom_range(0, 8)]);
                if ($urandom_range(0, 1) == 1) drain(60);
                else repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain(2000);
        chk("pop_count", 32'(popped), 32'(pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
